// File: rtl/riscv_decode_pkg.sv
// Shared constants for the RV32I(+M) ID stage: opcodes, funct3/funct7 values,
// ALU operation codes, ALU operand selects and the decoded control bundle.
package riscv_decode_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_LUI  = 5'd2;
  localparam logic [4:0] ALU_AND  = 5'd3;
  localparam logic [4:0] ALU_XOR  = 5'd4;
  localparam logic [4:0] ALU_OR   = 5'd5;
  localparam logic [4:0] ALU_SLL  = 5'd6;
  localparam logic [4:0] ALU_SRL  = 5'd7;
  localparam logic [4:0] ALU_SRA  = 5'd8;
  localparam logic [4:0] ALU_SLT  = 5'd9;
  localparam logic [4:0] ALU_SLTU = 5'd10;
  localparam logic [4:0] ALU_MUL  = 5'd16;  // M ops are ALU_MUL + funct3

  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_IMM  = 2'd1;
  localparam logic [1:0] SRC_B_FOUR = 2'd2;

  typedef struct packed {
    logic [4:0] alu_code;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic       illegal;
  } ctrl_t;

  function automatic logic [4:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD_SUB: alu_from_f3 = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     alu_from_f3 = ALU_SLL;
      F3_SLT:     alu_from_f3 = ALU_SLT;
      F3_SLTU:    alu_from_f3 = ALU_SLTU;
      F3_XOR:     alu_from_f3 = ALU_XOR;
      F3_SR:      alu_from_f3 = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      alu_from_f3 = ALU_OR;
      default:    alu_from_f3 = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// IF/ID -> ID -> EX handshake and control-bundle signals of the decode stage.
interface decode_stage_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            flush;
  logic            ex_ready;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_funct3;
  logic [4:0]      out_alu_code;
  logic            out_alu_src_a;
  logic [1:0]      out_alu_src_b;
  logic            out_mem_read;
  logic            out_mem_write;
  logic            out_mem_to_reg;
  logic            out_reg_write;
  logic            out_branch;
  logic            out_jump;
  logic            out_jalr;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, flush, ex_ready,
    input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm, out_funct3,
           out_alu_code, out_alu_src_a, out_alu_src_b, out_mem_read, out_mem_write,
           out_mem_to_reg, out_reg_write, out_branch, out_jump, out_jalr, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, ex_ready,
    output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm, out_funct3,
           out_alu_code, out_alu_src_a, out_alu_src_b, out_mem_read, out_mem_write,
           out_mem_to_reg, out_reg_write, out_branch, out_jump, out_jalr, out_illegal
  );
endinterface

// File: rtl/imm_gen.sv
// Immediate extraction by opcode format (I/S/B/U/J), sign-extended to XLEN.
module imm_gen
  import riscv_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm
);

  logic signed [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (instr[6:0])
      OP_IMM, OP_LOAD, OP_JALR: imm32 = {{20{instr[31]}}, instr[31:20]};
      OP_STORE:                 imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OP_BRANCH:                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC:         imm32 = {instr[31:12], 12'b0};
      OP_JAL:                   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:                  imm32 = '0;
    endcase
  end

  // signed size cast replicates bit 31 up to XLEN
  assign imm = XLEN'(imm32);

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I(+M) ID stage: decodes one instruction per cycle into the ID/EX
// bundle with valid/ready handshake, flush and load-use bubble insertion.
module decode_stage
  import riscv_decode_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ENABLE_M  = 0,
  parameter int HAZARD_EN = 1
) (
  input logic            clk,
  input logic            reset,
  decode_stage_if.slave  bus
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;
  logic [XLEN-1:0] imm;
  ctrl_t ctrl;
  logic uses_rs1;
  logic uses_rs2;
  logic hazard;
  logic accept;

  logic            valid_reg;
  logic [XLEN-1:0] pc_reg;
  logic [4:0]      rs1_reg;
  logic [4:0]      rs2_reg;
  logic [4:0]      rd_reg;
  logic [XLEN-1:0] imm_reg;
  logic [2:0]      funct3_reg;
  ctrl_t           ctrl_reg;

  assign opcode = bus.in_instr[6:0];
  assign rd     = bus.in_instr[11:7];
  assign funct3 = bus.in_instr[14:12];
  assign rs1    = bus.in_instr[19:15];
  assign rs2    = bus.in_instr[24:20];
  assign funct7 = bus.in_instr[31:25];

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (bus.in_instr),
    .imm   (imm)
  );

  always_comb begin
    ctrl     = '0;
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    case (opcode)
      OP_REG: begin
        uses_rs2       = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_b = SRC_B_RS2;
        if (funct7 == F7_MULDIV) begin
          if (ENABLE_M != 0) ctrl.alu_code = {2'b10, funct3};
          else               ctrl.illegal  = 1'b1;
        end else if (funct7 == F7_BASE || funct7 == F7_ALT) begin
          ctrl.alu_code = alu_from_f3(funct3, funct7[5]);
          if (funct7 == F7_ALT && funct3 != F3_ADD_SUB && funct3 != F3_SR) ctrl.illegal = 1'b1;
        end else begin
          ctrl.illegal = 1'b1;
        end
      end
      OP_IMM: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_code  = alu_from_f3(funct3, 1'b0);
        // shift-immediates carry funct7 in the upper immediate bits
        if (funct3 == F3_SLL && funct7 != F7_BASE) ctrl.illegal = 1'b1;
        if (funct3 == F3_SR) begin
          if (funct7 == F7_ALT)       ctrl.alu_code = ALU_SRA;
          else if (funct7 != F7_BASE) ctrl.illegal  = 1'b1;
        end
      end
      OP_LOAD: begin
        ctrl.alu_src_b  = SRC_B_IMM;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) ctrl.illegal = 1'b1;
      end
      OP_STORE: begin
        uses_rs2       = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.mem_write = 1'b1;
        if (funct3 > 3'b010) ctrl.illegal = 1'b1;
      end
      OP_BRANCH: begin
        uses_rs2       = 1'b1;
        ctrl.alu_code  = ALU_SUB;
        ctrl.alu_src_b = SRC_B_RS2;
        ctrl.branch    = 1'b1;
        if (funct3 == 3'b010 || funct3 == 3'b011) ctrl.illegal = 1'b1;
      end
      OP_LUI: begin
        uses_rs1       = 1'b0;
        ctrl.alu_code  = ALU_LUI;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.reg_write = 1'b1;
      end
      OP_AUIPC: begin
        uses_rs1       = 1'b0;
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.reg_write = 1'b1;
      end
      OP_JAL: begin
        uses_rs1       = 1'b0;
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.jump      = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_JALR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.jalr      = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      default: ctrl.illegal = 1'b1;
    endcase
    if (ctrl.illegal) begin
      ctrl         = '0;
      ctrl.illegal = 1'b1;
    end
  end

  assign hazard = (HAZARD_EN != 0) && valid_reg && ctrl_reg.mem_read && (rd_reg != 5'd0) &&
                  bus.in_valid && ((uses_rs1 && rs1 == rd_reg) || (uses_rs2 && rs2 == rd_reg));

  assign bus.in_ready = !bus.flush && !hazard && (!valid_reg || bus.ex_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg  <= 1'b0;
      pc_reg     <= '0;
      rs1_reg    <= '0;
      rs2_reg    <= '0;
      rd_reg     <= '0;
      imm_reg    <= '0;
      funct3_reg <= '0;
      ctrl_reg   <= '0;
    end else if (bus.flush) begin
      valid_reg <= 1'b0;
    end else if (accept) begin
      valid_reg  <= 1'b1;
      pc_reg     <= bus.in_pc;
      rs1_reg    <= rs1;
      rs2_reg    <= rs2;
      rd_reg     <= ctrl.reg_write ? rd : 5'd0;
      imm_reg    <= imm;
      funct3_reg <= funct3;
      ctrl_reg   <= ctrl;
    end else if (bus.ex_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign bus.out_valid      = valid_reg;
  assign bus.out_pc         = pc_reg;
  assign bus.out_rs1        = rs1_reg;
  assign bus.out_rs2        = rs2_reg;
  assign bus.out_rd         = rd_reg;
  assign bus.out_imm        = imm_reg;
  assign bus.out_funct3     = funct3_reg;
  assign bus.out_alu_code   = ctrl_reg.alu_code;
  assign bus.out_alu_src_a  = ctrl_reg.alu_src_a;
  assign bus.out_alu_src_b  = ctrl_reg.alu_src_b;
  assign bus.out_mem_read   = ctrl_reg.mem_read;
  assign bus.out_mem_write  = ctrl_reg.mem_write;
  assign bus.out_mem_to_reg = ctrl_reg.mem_to_reg;
  assign bus.out_reg_write  = ctrl_reg.reg_write;
  assign bus.out_branch     = ctrl_reg.branch;
  assign bus.out_jump       = ctrl_reg.jump;
  assign bus.out_jalr       = ctrl_reg.jalr;
  assign bus.out_illegal    = ctrl_reg.illegal;

endmodule
